// File: rtl/audio_dac_serializer_if.sv
// FIFO-side bundle of the audio DAC serializer: show-ahead head words, empty flags and pop strobes.
// master = serializer (consumer), slave = the left/right sample FIFOs.
interface audio_dac_serializer_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  left_fifo_empty;
    logic [DATA_WIDTH-1:0] left_fifo_data;
    logic                  left_read_en;
    logic                  right_fifo_empty;
    logic [DATA_WIDTH-1:0] right_fifo_data;
    logic                  right_read_en;

    modport master (
        input  left_fifo_empty, left_fifo_data, right_fifo_empty, right_fifo_data,
        output left_read_en, right_read_en
    );

    modport slave (
        output left_fifo_empty, left_fifo_data, right_fifo_empty, right_fifo_data,
        input  left_read_en, right_read_en
    );
endinterface

// File: rtl/audio_dac_serializer.sv
// I2S DAC serializer: one left/right FIFO pop per LRCLK frame, shifted out MSB-first on BCLK falling strobes.
// Optional macro AUDIO_DAC_UNDERRUN_REPEAT_EN replays the last popped samples on underrun instead of zeros.
module audio_dac_serializer #(
    parameter int DATA_WIDTH  = 32,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic                   bclk_falling_edge,
    input  logic                   lrclk_falling_edge,
    input  logic                   lrclk_rising_edge,
    audio_dac_serializer_if.master fifo,
    output logic                   serial_data,
    output logic                   underrun,
    output logic [COUNT_WIDTH-1:0] underrun_count
);
    localparam int BIT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, WAIT_FRAME, LEFT, RIGHT} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] hold_reg;
    logic [DATA_WIDTH-1:0] refill_left;
    logic [DATA_WIDTH-1:0] refill_right;
    logic [BIT_W-1:0]      bit_count;
    logic                  frame_start;
    logic                  frame_pop;

    // A frame only starts from WAIT_FRAME or RIGHT, so playback never begins mid-frame.
    assign frame_start = enable && lrclk_falling_edge && (state == WAIT_FRAME || state == RIGHT);
    assign frame_pop   = frame_start && !fifo.left_fifo_empty && !fifo.right_fifo_empty;

`ifdef AUDIO_DAC_UNDERRUN_REPEAT_EN
    logic [DATA_WIDTH-1:0] last_left;
    logic [DATA_WIDTH-1:0] last_right;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_left  <= '0;
            last_right <= '0;
        end else if (frame_pop) begin
            last_left  <= fifo.left_fifo_data;
            last_right <= fifo.right_fifo_data;
        end
    end

    assign refill_left  = last_left;
    assign refill_right = last_right;
`else
    assign refill_left  = '0;
    assign refill_right = '0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            shift_reg         <= '0;
            hold_reg          <= '0;
            bit_count         <= '0;
            serial_data       <= 1'b0;
            fifo.left_read_en <= 1'b0;
            fifo.right_read_en <= 1'b0;
            underrun          <= 1'b0;
            underrun_count    <= '0;
        end else begin
            fifo.left_read_en  <= 1'b0;
            fifo.right_read_en <= 1'b0;
            underrun           <= 1'b0;
            if (!enable) begin
                state       <= IDLE;
                shift_reg   <= '0;
                hold_reg    <= '0;
                bit_count   <= '0;
                serial_data <= 1'b0;
            end else if (state == IDLE) begin
                state <= WAIT_FRAME;
            end else if (frame_start) begin
                // An empty FIFO on either side skips both pops so the channels stay paired.
                if (frame_pop) begin
                    shift_reg          <= fifo.left_fifo_data;
                    hold_reg           <= fifo.right_fifo_data;
                    fifo.left_read_en  <= 1'b1;
                    fifo.right_read_en <= 1'b1;
                end else begin
                    shift_reg <= refill_left;
                    hold_reg  <= refill_right;
                    underrun  <= 1'b1;
                    if (underrun_count != {COUNT_WIDTH{1'b1}})
                        underrun_count <= underrun_count + COUNT_WIDTH'(1);
                end
                bit_count <= BIT_W'(DATA_WIDTH);
                state     <= LEFT;
            end else if (state == LEFT && lrclk_rising_edge) begin
                shift_reg <= hold_reg;
                bit_count <= BIT_W'(DATA_WIDTH);
                state     <= RIGHT;
            end else if (bclk_falling_edge && (state == LEFT || state == RIGHT)) begin
                if (bit_count != '0) begin
                    serial_data <= shift_reg[DATA_WIDTH-1];
                    shift_reg   <= {shift_reg[DATA_WIDTH-2:0], 1'b0};
                    bit_count   <= bit_count - BIT_W'(1);
                end else begin
                    serial_data <= 1'b0;
                end
            end
        end
    end
endmodule
